// File: rtl/ifu_fetch_pkg.sv
// Shared widths, constants, FSM encodings and the fetched-word record for the
// instruction fetch stage.
package ifu_fetch_pkg;
  localparam int INST_DATA_BUS = 32;
  localparam int INST_ADDR_BUS = 32;

  localparam logic [INST_DATA_BUS-1:0] ZERO_WORD    = '0;
  localparam logic [INST_DATA_BUS-1:0] IFU_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_RESP = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [INST_DATA_BUS-1:0] inst;
    logic [INST_ADDR_BUS-1:0] addr;
  } fetch_word_t;

  function automatic logic [INST_ADDR_BUS-1:0] word_align(input logic [INST_ADDR_BUS-1:0] a);
    return {a[INST_ADDR_BUS-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifu_fetch_if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that absorbs a response
// landing while the decoder is stalled. Priority: flush > hold > buffer > load.
module ifu_fetch_if_id_reg
  import ifu_fetch_pkg::*;
#(
  parameter logic [INST_DATA_BUS-1:0] NOP_INST = IFU_NOP_INST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     hold,
  input  logic                     load,
  input  fetch_word_t              load_word,
  output logic [INST_DATA_BUS-1:0] ins,
  output logic [INST_ADDR_BUS-1:0] ins_addr,
  output logic                     ins_valid,
  output logic                     buf_full
);
  fetch_word_t buf_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins       <= NOP_INST;
      ins_addr  <= ZERO_WORD;
      ins_valid <= 1'b0;
      buf_word  <= '0;
      buf_full  <= 1'b0;
    end else if (flush) begin
      ins       <= NOP_INST;
      ins_addr  <= ZERO_WORD;
      ins_valid <= 1'b0;
      buf_full  <= 1'b0;
    end else if (hold) begin
      if (load) begin
        buf_word <= load_word;
        buf_full <= 1'b1;
      end
    end else if (buf_full) begin
      ins       <= buf_word.inst;
      ins_addr  <= buf_word.addr;
      ins_valid <= 1'b1;
      buf_full  <= 1'b0;
    end else if (load) begin
      ins       <= load_word.inst;
      ins_addr  <= load_word.addr;
      ins_valid <= 1'b1;
    end else begin
      // bubble: address is left as-is for debug visibility
      ins       <= NOP_INST;
      ins_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, runs a single-outstanding req/gnt/rvalid bus
// master and feeds the IF/ID register. Jumps redirect and squash in-flight data.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_DATA_BUS-1:0] NOP_INST = IFU_NOP_INST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     jump_flag_i,
  input  logic [INST_ADDR_BUS-1:0] jump_addr_i,
  input  logic                     hold_flag_i,
  output logic                     ibus_req_o,
  output logic [INST_ADDR_BUS-1:0] ibus_addr_o,
  input  logic                     ibus_gnt_i,
  input  logic                     ibus_rvalid_i,
  input  logic [INST_DATA_BUS-1:0] ibus_rdata_i,
  output logic [INST_DATA_BUS-1:0] ins_o,
  output logic [INST_ADDR_BUS-1:0] ins_addr_o,
  output logic                     ins_valid_o
);
  ifu_state_e               state;
  logic [INST_ADDR_BUS-1:0] pc;
  logic [INST_ADDR_BUS-1:0] jump_pc;
  logic                     kill;
  logic                     drain;
  logic                     buf_full;
  logic                     load;
  fetch_word_t              load_word;

  assign jump_pc   = word_align(jump_addr_i);
  assign load      = (state == IFU_RESP) && !drain && ibus_rvalid_i && !kill && !jump_flag_i;
  assign load_word = '{inst: ibus_rdata_i, addr: pc};

  // REQ spends its first cycle launching the registered request, so a fetch
  // with single-cycle gnt/rvalid takes three cycles end to end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IFU_IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      drain       <= 1'b0;
      ibus_req_o  <= 1'b0;
      ibus_addr_o <= RESET_PC;
    end else begin
      if (jump_flag_i) pc <= jump_pc;
      case (state)
        IFU_IDLE: state <= IFU_REQ;
        IFU_REQ: begin
          if (!ibus_req_o) begin
            ibus_req_o  <= 1'b1;
            ibus_addr_o <= jump_flag_i ? jump_pc : pc;
          end else if (ibus_gnt_i) begin
            ibus_req_o <= 1'b0;
            kill       <= jump_flag_i;
            state      <= IFU_RESP;
          end else if (jump_flag_i) begin
            ibus_addr_o <= jump_pc;
          end
        end
        IFU_RESP: begin
          if (drain) begin
            // waiting for the skid buffer to empty; a jump discards it anyway
            if (jump_flag_i || !buf_full) begin
              drain <= 1'b0;
              state <= IFU_REQ;
            end
          end else if (ibus_rvalid_i) begin
            kill  <= 1'b0;
            state <= IFU_REQ;
            if (!kill && !jump_flag_i) begin
              pc <= pc + 32'd4;
              if (hold_flag_i) begin
                drain <= 1'b1;
                state <= IFU_RESP;
              end
            end
          end else if (jump_flag_i) begin
            kill <= 1'b1;
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end
  end

  ifu_fetch_if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (jump_flag_i),
    .hold      (hold_flag_i),
    .load      (load),
    .load_word (load_word),
    .ins       (ins_o),
    .ins_addr  (ins_addr_o),
    .ins_valid (ins_valid_o),
    .buf_full  (buf_full)
  );
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: stimulus pushes expected bus addresses and
// decoder words into queues; a negedge monitor pops and compares them.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_flag_i = 1'b0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = '0;
  logic [31:0] ins_o;
  logic [31:0] ins_addr_o;
  logic        ins_valid_o;

  int total = 0;
  int bad = 0;
  logic [31:0] req_q[$];
  fetch_word_t ins_q[$];
  logic prev_hold = 1'b0;

  ifu_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .ins_o         (ins_o),
    .ins_addr_o    (ins_addr_o),
    .ins_valid_o   (ins_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!ibus_req_o && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (!ibus_req_o) begin
      bad++;
      $display("FAIL req_timeout got=0 want=1 t=%0t", $time);
    end
  endtask

  // one bus transaction: optional grant delay, single-cycle response
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int gdly, input bit exp_out);
    wait_req();
    req_q.push_back(a);
    for (int i = 0; i < gdly; i++) begin
      chk("req_held", {31'd0, ibus_req_o}, 32'd1);
      chk("addr_stable", ibus_addr_o, a);
      tick();
    end
    ibus_gnt_i = 1'b1;
    tick();
    ibus_gnt_i = 1'b0;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i = d;
    if (exp_out) ins_q.push_back('{inst: d, addr: a});
    tick();
    ibus_rvalid_i = 1'b0;
  endtask

  // monitor: handshakes and fresh (non-held) valid outputs
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ibus_req_o && ibus_gnt_i) begin
          total++;
          if (req_q.size() == 0) begin
            bad++;
            $display("FAIL bus_extra got=%h want=none", ibus_addr_o);
          end else begin
            logic [31:0] ea;
            ea = req_q.pop_front();
            if (ibus_addr_o !== ea) begin
              bad++;
              $display("FAIL bus_addr got=%h want=%h t=%0t", ibus_addr_o, ea, $time);
            end
          end
        end
        if (ins_valid_o && !prev_hold) begin
          total++;
          if (ins_q.size() == 0) begin
            bad++;
            $display("FAIL ins_extra got=%h@%h want=none t=%0t", ins_o, ins_addr_o, $time);
          end else begin
            fetch_word_t ew;
            ew = ins_q.pop_front();
            if (ins_o !== ew.inst || ins_addr_o !== ew.addr) begin
              bad++;
              $display("FAIL ins_word got=%h@%h want=%h@%h t=%0t", ins_o, ins_addr_o, ew.inst, ew.addr, $time);
            end
          end
        end
      end
      prev_hold = hold_flag_i;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, ibus_req_o}, 32'd0);
    chk("rst_addr", ibus_addr_o, 32'h0);
    chk("rst_ins", ins_o, 32'h13);
    chk("rst_ins_addr", ins_addr_o, 32'h0);
    chk("rst_valid", {31'd0, ins_valid_o}, 32'd0);
    rst_n = 1'b1;

    // basic fetch and one-cycle rvalid-to-output latency
    fetch(32'h0, 32'h0050_0093, 0, 1);
    chk("lat_valid", {31'd0, ins_valid_o}, 32'd1);
    chk("lat_ins", ins_o, 32'h0050_0093);
    chk("lat_addr", ins_addr_o, 32'h0);

    // grant delayed three cycles
    fetch(32'h4, 32'h0010_0113, 3, 1);

    // jump in RESP before rvalid: squash the returning word
    wait_req();
    req_q.push_back(32'h8);
    ibus_gnt_i = 1'b1;
    tick();
    ibus_gnt_i = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0103;
    tick();
    jump_flag_i = 1'b0;
    chk("jmp_valid", {31'd0, ins_valid_o}, 32'd0);
    chk("jmp_ins", ins_o, 32'h13);
    chk("jmp_ins_addr", ins_addr_o, 32'h0);
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i = 32'hDEAD_BEEF;
    tick();
    ibus_rvalid_i = 1'b0;
    chk("kill_drop", {31'd0, ins_valid_o}, 32'd0);
    fetch(32'h100, 32'h0030_0193, 0, 1);

    // hold while the next response arrives: it lands in the buffer
    hold_flag_i = 1'b1;
    fetch(32'h104, 32'h00A0_0113, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_ins", ins_o, 32'h0030_0193);
      chk("hold_addr", ins_addr_o, 32'h100);
      chk("hold_valid", {31'd0, ins_valid_o}, 32'd1);
      chk("hold_noreq", {31'd0, ibus_req_o}, 32'd0);
      tick();
    end
    hold_flag_i = 1'b0;
    tick();
    chk("rel_ins", ins_o, 32'h00A0_0113);
    chk("rel_addr", ins_addr_o, 32'h104);
    chk("rel_valid", {31'd0, ins_valid_o}, 32'd1);

    // jump during hold with a full buffer: buffer discarded
    hold_flag_i = 1'b1;
    fetch(32'h108, 32'h0000_0533, 0, 0);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0200;
    tick();
    jump_flag_i = 1'b0;
    chk("jh_ins", ins_o, 32'h13);
    chk("jh_valid", {31'd0, ins_valid_o}, 32'd0);
    chk("jh_ins_addr", ins_addr_o, 32'h0);
    hold_flag_i = 1'b0;
    tick();
    chk("jh_nobuf", {31'd0, ins_valid_o}, 32'd0);
    fetch(32'h200, 32'h0070_0213, 0, 1);

    // jump at request launch plus pc wrap-around
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFE;
    tick();
    jump_flag_i = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h0080_0293, 0, 1);
    fetch(32'h0, 32'h0090_0313, 0, 1);

    // asynchronous reset mid-RESP, then stray rvalid after release
    wait_req();
    req_q.push_back(32'h4);
    ibus_gnt_i = 1'b1;
    tick();
    ibus_gnt_i = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("arst_req", {31'd0, ibus_req_o}, 32'd0);
    chk("arst_addr", ibus_addr_o, 32'h0);
    chk("arst_ins", ins_o, 32'h13);
    chk("arst_valid", {31'd0, ins_valid_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i = 32'hBAD0_BAD0;
    tick();
    ibus_rvalid_i = 1'b0;
    chk("stray_valid", {31'd0, ins_valid_o}, 32'd0);
    chk("stray_ins", ins_o, 32'h13);
    fetch(32'h0, 32'h00B0_0393, 0, 1);

    repeat (3) tick();
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("ins_q_empty", ins_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
